// File: rtl/cam_request_pipeline.sv
// cam_request_pipeline
//
// Two-stage request pipeline that sits in front of the CAM forwarder. It
// accepts lookup/insert/delete requests and issues table reads in the
// accept cycle. The forwarder-corrected lookup result is decoded in stage 1.
// Stage 1 drives the table write/delete port, and a registered status
// response is returned to the requester.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid_i/ready_o request handshake
//   req_op_i            00 lookup, 01 insert, 10 delete, 11 reserved
//   req_key_i/data_i    request key and insert data
//   pipe_en_o           stage enable (table read enable, forwarder clk_en)
//   rd_key_o            table read address (combinational from req_key_i)
//   s1_key_o            stage-1 key, forwarder new_key_i
//   lkp_data_i/valid_i  forwarder-corrected result for s1_key_o
//   wr_key_o/data_o     table write key/data, also forwarder forward inputs
//   wr_write_o/del_o    insert/delete strobes
//   rsp_valid_o/ready_i response handshake
//   rsp_data_o          lookup data or old (overwritten/deleted) data
//   rsp_hit_o           key was present before the operation
//   rsp_status_o        00 OK, 01 UPDATED, 10 REJECTED, 11 NOT_FOUND
module cam_request_pipeline #(
  parameter int DATA_WIDTH      = 4,
  parameter int KEY_WIDTH       = 2,
  parameter bit ALLOW_OVERWRITE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [KEY_WIDTH-1:0]  req_key_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  pipe_en_o,
  output logic [KEY_WIDTH-1:0]  rd_key_o,
  output logic [KEY_WIDTH-1:0]  s1_key_o,
  input  logic [DATA_WIDTH-1:0] lkp_data_i,
  input  logic                  lkp_valid_i,
  output logic [KEY_WIDTH-1:0]  wr_key_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  wr_write_o,
  output logic                  wr_del_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_hit_o,
  output logic [1:0]            rsp_status_o
);

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_UPDATED   = 2'b01;
  localparam logic [1:0] ST_REJECTED  = 2'b10;
  localparam logic [1:0] ST_NOT_FOUND = 2'b11;

  logic                  accept;
  logic                  fire;

  logic                  s1_valid_q;
  logic [1:0]            s1_op_q;
  logic [KEY_WIDTH-1:0]  s1_key_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  logic                  wr_req_d;
  logic                  del_req_d;
  logic [DATA_WIDTH-1:0] rsp_data_d;
  logic                  rsp_hit_d;
  logic [1:0]            rsp_status_d;

  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_hit_q;
  logic [1:0]            rsp_status_q;

  // The whole pipe advances unless a response is stuck downstream.
  assign pipe_en_o   = !rsp_valid_q || rsp_ready_i;
  assign req_ready_o = pipe_en_o && !reset;
  assign accept      = req_valid_i && req_ready_o;
  assign rd_key_o    = req_key_i;

  // Accept -> S1 boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else if (pipe_en_o) begin
      s1_valid_q <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (pipe_en_o && accept) begin
      s1_op_q   <= req_op_i;
      s1_key_q  <= req_key_i;
      s1_data_q <= req_data_i;
    end
  end

  assign s1_key_o = s1_key_q;

  always_comb begin
    wr_req_d     = 1'b0;
    del_req_d    = 1'b0;
    rsp_data_d   = '0;
    rsp_hit_d    = lkp_valid_i;
    rsp_status_d = ST_REJECTED;
    case (s1_op_q)
      OP_LOOKUP: begin
        rsp_status_d = lkp_valid_i ? ST_OK : ST_NOT_FOUND;
        rsp_data_d   = lkp_valid_i ? lkp_data_i : '0;
      end
      OP_INSERT: begin
        if (!lkp_valid_i) begin
          wr_req_d     = 1'b1;
          rsp_status_d = ST_OK;
        end else if (ALLOW_OVERWRITE) begin
          wr_req_d     = 1'b1;
          rsp_status_d = ST_UPDATED;
          rsp_data_d   = lkp_data_i;
        end else begin
          rsp_status_d = ST_REJECTED;
          rsp_data_d   = lkp_data_i;
        end
      end
      OP_DELETE: begin
        if (lkp_valid_i) begin
          del_req_d    = 1'b1;
          rsp_status_d = ST_OK;
          rsp_data_d   = lkp_data_i;
        end else begin
          rsp_status_d = ST_NOT_FOUND;
        end
      end
      default: begin
        rsp_status_d = ST_REJECTED;
      end
    endcase
  end

  // Strobes only fire on a cycle the forwarder also registers (pipe_en_o),
  // so a stalled S1 entry writes exactly once.
  assign fire       = s1_valid_q && pipe_en_o && !reset;
  assign wr_write_o = fire && wr_req_d;
  assign wr_del_o   = fire && del_req_d;
  assign wr_key_o   = (wr_write_o || wr_del_o) ? s1_key_q : '0;
  assign wr_data_o  = wr_write_o ? s1_data_q : '0;

  // S1 -> response boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_hit_q    <= 1'b0;
      rsp_status_q <= ST_OK;
    end else if (pipe_en_o && s1_valid_q) begin
      rsp_valid_q  <= 1'b1;
      rsp_data_q   <= rsp_data_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_status_q <= rsp_status_d;
    end else if (rsp_ready_i) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_hit_o    = rsp_hit_q;
  assign rsp_status_o = rsp_status_q;

endmodule

// File: tb/tb_cam_request_pipeline.sv
// Testbench for cam_request_pipeline. Two instances share the request
// stream: _a with ALLOW_OVERWRITE=1, _b with ALLOW_OVERWRITE=0. Each has an
// ideal table model acting as table plus forwarder. A reference model
// predicts every response when the request is accepted, and a monitor pops
// and compares responses in order.
module tb_cam_request_pipeline;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid_i;
  logic [1:0] req_op_i;
  logic [1:0] req_key_i;
  logic [3:0] req_data_i;
  logic       rsp_ready_i;

  logic       req_ready_a, pipe_en_a, wr_write_a, wr_del_a, rsp_valid_a, rsp_hit_a, lkp_valid_a;
  logic [1:0] rd_key_a, s1_key_a, wr_key_a, rsp_status_a;
  logic [3:0] wr_data_a, rsp_data_a, lkp_data_a;
  logic       req_ready_b, pipe_en_b, wr_write_b, wr_del_b, rsp_valid_b, rsp_hit_b, lkp_valid_b;
  logic [1:0] rd_key_b, s1_key_b, wr_key_b, rsp_status_b;
  logic [3:0] wr_data_b, rsp_data_b, lkp_data_b;

  always #5 clk = ~clk;

  cam_request_pipeline #(.DATA_WIDTH(4), .KEY_WIDTH(2), .ALLOW_OVERWRITE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_ready_o(req_ready_a),
    .req_op_i(req_op_i), .req_key_i(req_key_i), .req_data_i(req_data_i),
    .pipe_en_o(pipe_en_a), .rd_key_o(rd_key_a), .s1_key_o(s1_key_a),
    .lkp_data_i(lkp_data_a), .lkp_valid_i(lkp_valid_a),
    .wr_key_o(wr_key_a), .wr_data_o(wr_data_a), .wr_write_o(wr_write_a), .wr_del_o(wr_del_a),
    .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_a),
    .rsp_hit_o(rsp_hit_a), .rsp_status_o(rsp_status_a));

  cam_request_pipeline #(.DATA_WIDTH(4), .KEY_WIDTH(2), .ALLOW_OVERWRITE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_ready_o(req_ready_b),
    .req_op_i(req_op_i), .req_key_i(req_key_i), .req_data_i(req_data_i),
    .pipe_en_o(pipe_en_b), .rd_key_o(rd_key_b), .s1_key_o(s1_key_b),
    .lkp_data_i(lkp_data_b), .lkp_valid_i(lkp_valid_b),
    .wr_key_o(wr_key_b), .wr_data_o(wr_data_b), .wr_write_o(wr_write_b), .wr_del_o(wr_del_b),
    .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_b),
    .rsp_hit_o(rsp_hit_b), .rsp_status_o(rsp_status_b));

  // Ideal table + forwarder: writes land at the edge, so the combinational
  // read of s1_key already reflects the previous cycle's write.
  logic       tv_a [4];
  logic [3:0] td_a [4];
  logic       tv_b [4];
  logic [3:0] td_b [4];
  logic       tbl_clr;

  assign lkp_valid_a = tv_a[s1_key_a];
  assign lkp_data_a  = td_a[s1_key_a];
  assign lkp_valid_b = tv_b[s1_key_b];
  assign lkp_data_b  = td_b[s1_key_b];

  always @(posedge clk) begin
    if (tbl_clr) begin
      for (int i = 0; i < 4; i++) begin
        tv_a[i] <= 1'b0; td_a[i] <= 4'h0; tv_b[i] <= 1'b0; td_b[i] <= 4'h0;
      end
    end else begin
      if (wr_write_a) begin tv_a[wr_key_a] <= 1'b1; td_a[wr_key_a] <= wr_data_a; end
      if (wr_del_a)   begin tv_a[wr_key_a] <= 1'b0; td_a[wr_key_a] <= 4'h0; end
      if (wr_write_b) begin tv_b[wr_key_b] <= 1'b1; td_b[wr_key_b] <= wr_data_b; end
      if (wr_del_b)   begin tv_b[wr_key_b] <= 1'b0; td_b[wr_key_b] <= 4'h0; end
    end
  end

  // Reference model state
  logic       ra_v [4];
  logic [3:0] ra_d [4];
  logic       rb_v [4];
  logic [3:0] rb_d [4];

  typedef struct packed {
    logic [3:0] d_a; logic h_a; logic [1:0] s_a;
    logic [3:0] d_b; logic h_b; logic [1:0] s_b;
  } exp_t;
  exp_t exp_q[$];

  int tests_run = 0;
  int fails     = 0;
  int n_wr_a = 0, n_wr_b = 0, n_del_a = 0, n_del_b = 0;

  // Response monitor / scoreboard, plus strobe counters.
  always @(negedge clk) begin
    exp_t e;
    if (wr_write_a) n_wr_a++;
    if (wr_write_b) n_wr_b++;
    if (wr_del_a)   n_del_a++;
    if (wr_del_b)   n_del_b++;
    if (!reset && rsp_valid_a && rsp_ready_i) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: got data_a=%h st_a=%b, expected no response", rsp_data_a, rsp_status_a);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_data_a, rsp_hit_a, rsp_status_a, rsp_valid_b, rsp_data_b, rsp_hit_b, rsp_status_b}
            !== {e.d_a, e.h_a, e.s_a, 1'b1, e.d_b, e.h_b, e.s_b}) begin
          fails++;
          $display("FAIL rsp: got a(d=%h h=%b s=%b) b(v=%b d=%h h=%b s=%b), expected a(d=%h h=%b s=%b) b(v=1 d=%h h=%b s=%b)",
                   rsp_data_a, rsp_hit_a, rsp_status_a, rsp_valid_b, rsp_data_b, rsp_hit_b, rsp_status_b,
                   e.d_a, e.h_a, e.s_a, e.d_b, e.h_b, e.s_b);
        end
      end
    end
  end

  task automatic model(input bit allow, input logic [1:0] op, input logic h, input logic [3:0] old,
                       output logic [1:0] s, output logic [3:0] d, output logic wr, output logic del);
    wr = 1'b0; del = 1'b0; d = 4'h0; s = 2'b10;
    case (op)
      2'b00: begin s = h ? 2'b00 : 2'b11; d = h ? old : 4'h0; end
      2'b01: begin
        if (!h)        begin s = 2'b00; wr = 1'b1; end
        else if (allow) begin s = 2'b01; d = old; wr = 1'b1; end
        else           begin s = 2'b10; d = old; end
      end
      2'b10: begin
        if (h) begin s = 2'b00; d = old; del = 1'b1; end
        else   s = 2'b11;
      end
      default: s = 2'b10;
    endcase
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] key, input logic [3:0] data);
    logic acc; int n; exp_t e; logic wr, del;
    req_valid_i = 1'b1; req_op_i = op; req_key_i = key; req_data_i = data;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk); acc = req_ready_a;
      @(posedge clk); #1;
      if (!acc) rsp_ready_i = 1'b1;
      n++;
    end
    if (!acc) begin
      tests_run++; fails++;
      $display("FAIL send_timeout: req_ready stayed %b, expected 1", req_ready_a);
    end else begin
      e.h_a = ra_v[key];
      model(1'b1, op, ra_v[key], ra_d[key], e.s_a, e.d_a, wr, del);
      if (wr)  begin ra_v[key] = 1'b1; ra_d[key] = data; end
      if (del) begin ra_v[key] = 1'b0; ra_d[key] = 4'h0; end
      e.h_b = rb_v[key];
      model(1'b0, op, rb_v[key], rb_d[key], e.s_b, e.d_b, wr, del);
      if (wr)  begin rb_v[key] = 1'b1; rb_d[key] = data; end
      if (del) begin rb_v[key] = 1'b0; rb_d[key] = 4'h0; end
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    req_valid_i = 1'b0; rsp_ready_i = 1'b1; n = 0;
    while ((exp_q.size() != 0 || rsp_valid_a) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0 || rsp_valid_a) begin
      tests_run++; fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tbl_clr = 1'b1; rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_op_i = 2'b01; req_key_i = 2'd3; req_data_i = 4'hF;
    for (int i = 0; i < 4; i++) begin ra_v[i] = 0; ra_d[i] = 0; rb_v[i] = 0; rb_d[i] = 0; end
    repeat (3) @(posedge clk);
    #1 tbl_clr = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({rsp_valid_a, rsp_data_a, rsp_hit_a, rsp_status_a} !== 8'h00) begin
      fails++; $display("FAIL reset_rsp: got %b, expected 00000000", {rsp_valid_a, rsp_data_a, rsp_hit_a, rsp_status_a});
    end
    tests_run++;
    if ({wr_write_a, wr_del_a, wr_write_b, wr_del_b, req_ready_a} !== 5'b0) begin
      fails++; $display("FAIL reset_strobes: got wr/del/ready=%b, expected 00000", {wr_write_a, wr_del_a, wr_write_b, wr_del_b, req_ready_a});
    end
    tests_run++;
    if ({pipe_en_a, pipe_en_b} !== 2'b11) begin
      fails++; $display("FAIL reset_pipe_en: got %b, expected 11", {pipe_en_a, pipe_en_b});
    end
    @(posedge clk); #1 reset = 1'b0; req_valid_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({req_ready_a, req_ready_b, rsp_valid_a} !== 3'b110) begin
      fails++; $display("FAIL release_ready: got %b, expected 110", {req_ready_a, req_ready_b, rsp_valid_a});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_insert_forward();
    send(2'b01, 2'd2, 4'hA);
    send(2'b00, 2'd2, 4'h0);
    drain();
  endtask

  task automatic test_overwrite();
    send(2'b01, 2'd1, 4'h3);
    send(2'b01, 2'd1, 4'h5);
    send(2'b00, 2'd1, 4'h0);
    drain();
  endtask

  task automatic test_reserved();
    send(2'b11, 2'd2, 4'h7);
    send(2'b11, 2'd3, 4'h7);
    send(2'b00, 2'd3, 4'h0);
    drain();
  endtask

  task automatic test_delete();
    int c_a, c_b;
    c_a = n_del_a; c_b = n_del_b;
    send(2'b10, 2'd1, 4'h0);
    send(2'b10, 2'd1, 4'h0);
    drain();
    tests_run++;
    if ((n_del_a - c_a) != 1 || (n_del_b - c_b) != 1) begin
      fails++; $display("FAIL delete_strobes: got a=%0d b=%0d pulses, expected 1 each", n_del_a - c_a, n_del_b - c_b);
    end
  endtask

  task automatic test_backpressure();
    int c_a, c_b;
    c_a = n_wr_a; c_b = n_wr_b;
    rsp_ready_i = 1'b0;
    send(2'b00, 2'd2, 4'h0);
    send(2'b01, 2'd3, 4'h7);
    req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({pipe_en_a, wr_write_a, wr_write_b, rsp_valid_a} !== 4'b0001) begin
        fails++; $display("FAIL bp_hold%0d: got pipe_en/wr_a/wr_b/rsp_valid=%b, expected 0001", i, {pipe_en_a, wr_write_a, wr_write_b, rsp_valid_a});
      end
      @(posedge clk); #1;
    end
    drain();
    tests_run++;
    if ((n_wr_a - c_a) != 1 || (n_wr_b - c_b) != 1) begin
      fails++; $display("FAIL bp_writes: got a=%0d b=%0d strobes, expected 1 each", n_wr_a - c_a, n_wr_b - c_b);
    end
  endtask

  task automatic test_reset_midop();
    int c_a;
    c_a = n_wr_a;
    req_valid_i = 1'b1; req_op_i = 2'b01; req_key_i = 2'd0; req_data_i = 4'h9;
    @(posedge clk); #1;
    req_valid_i = 1'b0; reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({wr_write_a, wr_write_b, req_ready_a} !== 3'b000) begin
      fails++; $display("FAIL midreset_strobe: got wr_a/wr_b/ready=%b, expected 000", {wr_write_a, wr_write_b, req_ready_a});
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({rsp_valid_a, rsp_valid_b, wr_write_a} !== 3'b000) begin
      fails++; $display("FAIL midreset_rsp: got rsp_a/rsp_b/wr=%b, expected 000", {rsp_valid_a, rsp_valid_b, wr_write_a});
    end
    @(posedge clk); #1;
    send(2'b00, 2'd0, 4'h0);
    drain();
    tests_run++;
    if (n_wr_a != c_a) begin
      fails++; $display("FAIL midreset_writes: got %0d strobes, expected 0", n_wr_a - c_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end
    drain();
  endtask

  initial begin
    reset = 1'b1; tbl_clr = 1'b1; req_valid_i = 1'b0; req_op_i = 2'b00;
    req_key_i = 2'd0; req_data_i = 4'h0; rsp_ready_i = 1'b1;
    test_reset();
    test_insert_forward();
    test_overwrite();
    test_reserved();
    test_delete();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
